// File: rtl/nice_hw_deque_pkg.sv
// Shared types for the hardware deque: command codes and controller states.
package nice_hw_deque_pkg;

  typedef enum logic [1:0] {
    OP_PUSH_FRONT = 2'd0,
    OP_PUSH_BACK  = 2'd1,
    OP_POP_FRONT  = 2'd2,
    OP_POP_BACK   = 2'd3
  } deque_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } deque_state_e;

  function automatic logic is_push(deque_op_e op);
    return (op == OP_PUSH_FRONT) || (op == OP_PUSH_BACK);
  endfunction

endpackage

// File: rtl/nice_hw_deque_ram.sv
// Deque element storage: one synchronous write port, one combinational read port.
module nice_hw_deque_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; contents are only read where valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/nice_hw_deque.sv
// Double-ended queue over a circular buffer with a front-to-back snapshot stream.
// Optional build macro NICE_HW_DEQUE_STATS_EN adds saturating reject counters
// (ovf_cnt for pushes when full, udf_cnt for pops when empty).
module nice_hw_deque
  import nice_hw_deque_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [1:0]             op_code,
  input  logic [DATA_W-1:0]      op_data,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_err,
  input  logic                   iter_start,
  output logic                   iter_valid,
  input  logic                   iter_ready,
  output logic [DATA_W-1:0]      iter_data,
  output logic                   iter_last,
  output logic [$clog2(DEPTH):0] size,
  output logic                   empty,
  output logic                   full
`ifdef NICE_HW_DEQUE_STATS_EN
  ,
  output logic [15:0]            ovf_cnt,
  output logic [15:0]            udf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;

  deque_state_e      state;
  deque_op_e         op;
  logic [AW-1:0]     head, tail, iter_ptr;
  logic [AW-1:0]     head_inc, head_dec, tail_inc, tail_dec;
  logic [SW-1:0]     iter_left;
  logic              accept, reject, is_push_op, wr_en;
  logic [AW-1:0]     wr_addr, rd_addr;
  logic [DATA_W-1:0] rd_data;

  assign op         = deque_op_e'(op_code);
  assign head_inc   = head + AW'(1);
  assign head_dec   = head - AW'(1);
  assign tail_inc   = tail + AW'(1);
  assign tail_dec   = tail - AW'(1);
  assign empty      = (size == '0);
  assign full       = (size == SW'(DEPTH));
  // A pending iter_start takes priority over any command in the same cycle.
  assign op_ready   = (state == ST_IDLE) && !iter_start;
  assign accept     = op_valid && op_ready;
  assign is_push_op = is_push(op);
  assign reject     = is_push_op ? full : empty;
  assign wr_en      = accept && !reject && is_push_op;
  assign wr_addr    = (op == OP_PUSH_FRONT) ? head_dec : tail;

  // Single read port: prefetch the next beat while streaming, otherwise serve pops.
  always_comb begin
    rd_addr = head;
    if (state == ST_ITER)      rd_addr = iter_ptr + AW'(1);
    else if (iter_start)       rd_addr = head;
    else if (op == OP_POP_BACK) rd_addr = tail_dec;
  end

  nice_hw_deque_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (op_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Controller: command execution in IDLE, snapshot streaming in ITER.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      head       <= '0;
      tail       <= '0;
      size       <= '0;
      iter_ptr   <= '0;
      iter_left  <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      iter_valid <= 1'b0;
      iter_last  <= 1'b0;
      iter_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (iter_start) begin
            if (size != '0) begin
              state      <= ST_ITER;
              iter_ptr   <= head;
              iter_left  <= size;
              iter_valid <= 1'b1;
              iter_data  <= rd_data;
              iter_last  <= (size == SW'(1));
            end
          end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_err   <= reject;
            if (!reject) begin
              unique case (op)
                OP_PUSH_FRONT: begin head <= head_dec; size <= size + SW'(1); end
                OP_PUSH_BACK:  begin tail <= tail_inc; size <= size + SW'(1); end
                OP_POP_FRONT:  begin rsp_data <= rd_data; head <= head_inc; size <= size - SW'(1); end
                OP_POP_BACK:   begin rsp_data <= rd_data; tail <= tail_dec; size <= size - SW'(1); end
              endcase
            end
          end
        end
        ST_ITER: begin
          if (iter_ready) begin
            if (iter_last) begin
              state      <= ST_IDLE;
              iter_valid <= 1'b0;
              iter_last  <= 1'b0;
              iter_data  <= '0;
            end else begin
              iter_ptr  <= iter_ptr + AW'(1);
              iter_left <= iter_left - SW'(1);
              iter_data <= rd_data;
              iter_last <= (iter_left == SW'(2));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef NICE_HW_DEQUE_STATS_EN
  // Saturating counts of rejected pushes (overflow) and pops (underflow).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else if (accept && reject) begin
      if (is_push_op) begin
        if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
      end else begin
        if (udf_cnt != 16'hFFFF) udf_cnt <= udf_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nice_hw_deque.sv
// Bench for nice_hw_deque: queue-based reference model with per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_nice_hw_deque;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int SW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              op_valid, op_ready;
  logic [1:0]        op_code;
  logic [DATA_W-1:0] op_data;
  logic              rsp_valid, rsp_err;
  logic [DATA_W-1:0] rsp_data;
  logic              iter_start, iter_valid, iter_ready, iter_last;
  logic [DATA_W-1:0] iter_data;
  logic [SW-1:0]     dut_size;
  logic              empty, full;
`ifdef NICE_HW_DEQUE_STATS_EN
  logic [15:0]       ovf_cnt, udf_cnt;
`endif

  always #5 clk = ~clk;

  nice_hw_deque #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_data(op_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .iter_start(iter_start), .iter_valid(iter_valid), .iter_ready(iter_ready),
    .iter_data(iter_data), .iter_last(iter_last),
    .size(dut_size), .empty(empty), .full(full)
`ifdef NICE_HW_DEQUE_STATS_EN
    , .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt)
`endif
  );

  // Reference model
  logic [DATA_W-1:0] m_q[$];
  bit                m_iter;
  int                m_pos, m_beats;
  bit                m_rsp_v, m_rsp_e;
  logic [DATA_W-1:0] m_rsp_d;
  int                m_ovf, m_udf;
  int                tests = 0, fails = 0;
  bit                chk_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_iter = 0; m_pos = 0;
    m_rsp_v = 0; m_rsp_e = 0; m_rsp_d = '0;
    m_ovf = 0; m_udf = 0;
  endtask

  // Advance the model by one accepted clock edge using the inputs the DUT saw.
  task automatic model_step();
    m_rsp_v = 0; m_rsp_e = 0; m_rsp_d = '0;
    if (m_iter) begin
      if (iter_ready) begin
        m_beats++;
        if (m_pos == m_q.size() - 1) m_iter = 0;
        else m_pos++;
      end
    end else if (iter_start) begin
      if (m_q.size() != 0) begin m_iter = 1; m_pos = 0; m_beats = 0; end
    end else if (op_valid) begin
      m_rsp_v = 1;
      case (op_code)
        2'd0: if (m_q.size() == DEPTH) m_rsp_e = 1; else m_q.push_front(op_data);
        2'd1: if (m_q.size() == DEPTH) m_rsp_e = 1; else m_q.push_back(op_data);
        2'd2: if (m_q.size() == 0) m_rsp_e = 1; else m_rsp_d = m_q.pop_front();
        default: if (m_q.size() == 0) m_rsp_e = 1; else m_rsp_d = m_q.pop_back();
      endcase
      if (m_rsp_e) begin
        if (op_code < 2'd2) m_ovf = (m_ovf < 65535) ? m_ovf + 1 : m_ovf;
        else                m_udf = (m_udf < 65535) ? m_udf + 1 : m_udf;
      end
      $display("[TB] op=%0d data=%0h -> rsp_data=%0h err=%0d size=%0d",
               op_code, op_data, m_rsp_d, m_rsp_e, m_q.size());
    end
  endtask

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_v));
      if (m_rsp_v) begin
        check("rsp_err", 64'(rsp_err), 64'(m_rsp_e));
        check("rsp_data", 64'(rsp_data), 64'(m_rsp_d));
      end
      check("size", 64'(dut_size), 64'(m_q.size()));
      check("empty", 64'(empty), 64'(m_q.size() == 0));
      check("full", 64'(full), 64'(m_q.size() == DEPTH));
      check("op_ready", 64'(op_ready), 64'(!m_iter && !iter_start));
      check("iter_valid", 64'(iter_valid), 64'(m_iter));
      if (m_iter) begin
        check("iter_data", 64'(iter_data), 64'(m_q[m_pos]));
        check("iter_last", 64'(iter_last), 64'(m_pos == m_q.size() - 1));
      end
`ifdef NICE_HW_DEQUE_STATS_EN
      check("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
      check("udf_cnt", 64'(udf_cnt), 64'(m_udf));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    op_valid = 0; iter_start = 0; iter_ready = 0;
    rst_n = 0;
    model_reset();
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 0);
    check("rst_rsp_data", 64'(rsp_data), 0);
    check("rst_rsp_err", 64'(rsp_err), 0);
    check("rst_iter_valid", 64'(iter_valid), 0);
    check("rst_iter_last", 64'(iter_last), 0);
    check("rst_iter_data", 64'(iter_data), 0);
    check("rst_size", 64'(dut_size), 0);
    check("rst_empty", 64'(empty), 1);
    check("rst_full", 64'(full), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
  endtask

  task automatic do_op(input logic [1:0] code, input logic [DATA_W-1:0] data);
    op_valid = 1; op_code = code; op_data = data;
    tick();
    op_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat[5];
    logic [DATA_W-1:0] expd[5];
    int dut_beats, dut_last, budget;

    rst_n = 1; op_valid = 0; op_code = 0; op_data = 0; iter_start = 0; iter_ready = 0;
    #2;
    do_reset();
    chk_en = 1;

    // Push back 1,2,3 then pop front three times.
    for (int i = 1; i <= 3; i++) do_op(2'd1, DATA_W'(i));
    for (int i = 1; i <= 3; i++) begin
      do_op(2'd2, 0);
      check("fifo_pop_data", 64'(rsp_data), 64'(i));
      check("fifo_pop_err", 64'(rsp_err), 0);
    end
    check("fifo_size_end", 64'(dut_size), 0);

    // Push front 1,2,3 then pop front gives 3,2,1; then back-end LIFO.
    for (int i = 1; i <= 3; i++) do_op(2'd0, DATA_W'(i));
    for (int i = 3; i >= 1; i--) begin
      do_op(2'd2, 0);
      check("lifo_pop_data", 64'(rsp_data), 64'(i));
    end
    do_op(2'd1, 5);
    do_op(2'd1, 6);
    do_op(2'd3, 0);
    check("pop_back_data", 64'(rsp_data), 6);
    do_op(2'd2, 0);
    check("pop_front_rest", 64'(rsp_data), 5);

    // Fill, overflow, drain, underflow.
    for (int i = 0; i < 16; i++) do_op(2'd1, DATA_W'(32'h100 + i));
    check("full_after_16", 64'(full), 1);
    do_op(2'd0, 32'hDEAD);
    check("ovf_err", 64'(rsp_err), 1);
    check("ovf_size", 64'(dut_size), 16);
    for (int i = 0; i < 17; i++) begin
      do_op(2'd2, 0);
      if (i < 16) check("drain_data", 64'(rsp_data), 64'(32'h100 + i));
    end
    check("udf_err", 64'(rsp_err), 1);
    check("udf_data", 64'(rsp_data), 0);
`ifdef NICE_HW_DEQUE_STATS_EN
    check("ovf_cnt_lit", 64'(ovf_cnt), 1);
    check("udf_cnt_lit", 64'(udf_cnt), 1);
`endif

    // Wrap-around then full iteration.
    do_reset();
    for (int i = 0; i < 10; i++) do_op(2'd1, DATA_W'(100 + i));
    for (int i = 0; i < 8; i++) do_op(2'd2, 0);
    for (int i = 0; i < 12; i++) do_op(2'd1, DATA_W'(200 + i));
    check("wrap_size", 64'(dut_size), 14);
    iter_start = 1; tick(); iter_start = 0;
    iter_ready = 1; dut_beats = 0; dut_last = 0; budget = 40;
    while (iter_valid && budget > 0) begin
      check("wrap_iter_data", 64'(iter_data),
            64'((dut_beats < 2) ? 108 + dut_beats : 200 + dut_beats - 2));
      dut_beats++;
      if (iter_last) dut_last = dut_beats;
      tick();
      budget--;
    end
    iter_ready = 0;
    check("wrap_iter_budget", 64'(m_iter), 0);
    check("wrap_beats", 64'(dut_beats), 14);
    check("wrap_last_beat", 64'(dut_last), 14);
    check("wrap_size_kept", 64'(dut_size), 14);

    // Stalled iteration with a competing command held throughout.
    do_reset();
    do_op(2'd1, 32'hA); do_op(2'd1, 32'hB); do_op(2'd1, 32'hC);
    pat  = '{1, 0, 0, 1, 1};
    expd = '{32'hA, 32'hB, 32'hB, 32'hB, 32'hC};
    op_valid = 1; op_code = 2'd1; op_data = 32'hD; iter_start = 1;
    #1;
    check("start_blocks_op", 64'(op_ready), 0);
    tick();
    iter_start = 0;
    for (int i = 0; i < 5; i++) begin
      iter_ready = pat[i][0];
      #1;
      check("stall_iter_data", 64'(iter_data), 64'(expd[i]));
      check("stall_iter_last", 64'(iter_last), 64'(i == 4));
      check("stall_op_ready", 64'(op_ready), 0);
      check("stall_size", 64'(dut_size), 3);
      tick();
    end
    iter_ready = 0;
    check("stall_done_valid", 64'(iter_valid), 0);
    check("stall_done_ready", 64'(op_ready), 1);
    tick();
    op_valid = 0;
    check("held_op_rsp", 64'(rsp_valid), 1);
    check("held_op_size", 64'(dut_size), 4);

    // Reset in the middle of a stream.
    do_reset();
    for (int i = 1; i <= 5; i++) do_op(2'd1, DATA_W'(i));
    iter_start = 1; tick(); iter_start = 0;
    iter_ready = 1; tick(); tick(); iter_ready = 0;
    check("mid_iter_active", 64'(iter_valid), 1);
    check("mid_iter_data", 64'(iter_data), 3);
    do_reset();

    // Empty-deque iteration request is ignored.
    iter_start = 1; tick(); iter_start = 0;
    check("empty_iter_ignored", 64'(iter_valid), 0);

    // Randomized traffic in alternating push-heavy / pop-heavy phases.
    for (int c = 0; c < 1600; c++) begin
      int r;
      r = $urandom_range(0, 9);
      op_valid   = ($urandom_range(0, 9) < 7);
      op_data    = $urandom;
      if (((c / 200) % 2) == 0) op_code = (r < 7) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      else                      op_code = (r < 7) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      iter_start = ($urandom_range(0, 49) == 0);
      iter_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    op_valid = 0; iter_start = 0; iter_ready = 1;
    budget = 64;
    while (m_iter && budget > 0) begin tick(); budget--; end
    check("final_drain", 64'(m_iter), 0);
    iter_ready = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nice_hw_deque.md
NICE_HW_DEQUE -- requirements
Module: nice_hw_deque

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning element width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning capacity in elements; power of two, >=2.
REQ-003 SHALL have a single clock clk and an asynchronous, active-low reset rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 op_valid  input  1  command request.
REQ-007 op_ready  output  1  command accepted when op_valid&&op_ready.
REQ-008 op_code  input  2  command: 0 PUSH_FRONT, 1 PUSH_BACK, 2 POP_FRONT, 3 POP_BACK.
REQ-009 op_data  input  DATA_W  push payload; ignored for pops.
REQ-010 rsp_valid  output  1  one-cycle response pulse per accepted command.
REQ-011 rsp_data  output  DATA_W  popped element; 0 for pushes and errors.
REQ-012 rsp_err  output  1  command rejected: push when full, or pop when empty.
REQ-013 iter_start  input  1  pulse requesting a front-to-back snapshot stream.
REQ-014 iter_valid, iter_ready, iter_data[DATA_W], iter_last  out/in/out/out  valid/ready stream of contents.
REQ-015 size  output  $clog2(DEPTH)+1  current element count; empty and full outputs, 1 bit each.

Function
REQ-016 SHALL implement a circular buffer with head and tail pointers, each modulo DEPTH with wrap-around.
REQ-017 PUSH_BACK SHALL write at tail and advance tail; PUSH_FRONT SHALL decrement head, then write at the new head.
REQ-018 POP_FRONT SHALL return the element at head and advance head; POP_BACK SHALL decrement tail and return the element at the new tail.
REQ-019 rsp_valid SHALL assert exactly one cycle after acceptance; size/empty/full SHALL update in that same cycle.
REQ-020 Push when full or pop when empty SHALL set rsp_err=1 and rsp_data=0, with no change to pointers, size or storage.
REQ-021 FSM states SHALL be IDLE and ITER; op_ready=1 only in IDLE with iter_start low.
REQ-022 IDLE->ITER on iter_start when size>0; when size==0, iter_start SHALL be ignored and emit no beats.
REQ-023 If iter_start and op_valid are asserted in the same cycle, iter_start SHALL win and the op SHALL not be accepted.
REQ-024 ITER SHALL stream size elements, head first, one per iter_valid&&iter_ready handshake.
REQ-025 iter_data SHALL hold stable while iter_valid&&!iter_ready.
REQ-026 iter_last SHALL be 1 on the final beat; ITER->IDLE after the final handshake.
REQ-027 Iteration SHALL NOT modify storage or pointers; no ops are accepted in ITER.

Reset
REQ-028 On rst_n low: head=tail=0, size=0, empty=1, full=0, FSM=IDLE.
REQ-029 On rst_n low: rsp_valid=0, rsp_data=0, rsp_err=0, iter_valid=0, iter_last=0, iter_data=0.
REQ-030 Reset mid-iteration SHALL abort the stream immediately; storage contents are don't-care.

Configuration
REQ-031 NICE_HW_DEQUE_STATS_EN defined SHALL add two outputs, ovf_cnt[15:0] and udf_cnt[15:0], saturating counts of rejected pushes and pops, reset to 0.
REQ-032 Without NICE_HW_DEQUE_STATS_EN, those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-033 Package nice_hw_deque_pkg SHALL hold the op_code enum (deque_op_e) and the FSM state enum (deque_state_e).
REQ-034 Storage SHALL be a sub-module nice_hw_deque_ram: 1 write port, 1 combinational read port, DEPTH x DATA_W.

Verification
REQ-035 PUSH_BACK 1,2,3, then POP_FRONT x3 -> rsp_data 1,2,3, rsp_err=0, size ends at 0.
REQ-036 PUSH_FRONT 1,2,3, then POP_FRONT x3 -> rsp_data 3,2,1; PUSH_BACK 5,6, then POP_BACK -> 6.
REQ-037 DEPTH=16, 16 pushes -> full=1; 17th push -> rsp_err=1 and size stays 16; 17 pops -> last rsp_err=1 with rsp_data=0; under STATS_EN ovf_cnt=1, udf_cnt=1.
REQ-038 Wrap: PUSH_BACK x10, POP_FRONT x8, PUSH_BACK x12 -> size 14; iteration yields the 14 elements in order, iter_last on beat 14.
REQ-039 Iterate contents A,B,C with iter_ready toggling 1,0,0,1 -> iter_data held stable while stalled; op_valid held throughout is accepted only after the final beat.
REQ-040 Assert rst_n low mid-iteration after 2 of 5 beats -> iter_valid=0, size=0, empty=1 the same cycle.
